// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and serialises them as UART frames.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [15:0]           cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  par, bit_end, in_frame;
  assign bit_end   = cnt == 16'(CLKS_PER_BIT - 1);
  assign in_frame  = state inside {START, DATA, PARITY, STOP};
  assign shift_nxt = shift >> 1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par         <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      fifo_rd_en  <= 1'b0;
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= (in_frame && !bit_end) ? cnt + 16'd1 : 16'd0;
      case (state)
        IDLE: if (enable && !fifo_empty) begin
          state      <= POP;
          fifo_rd_en <= 1'b1;
          busy       <= 1'b1;
        end
        POP: state <= WAIT;
        WAIT: begin
          shift <= fifo_data;
          par   <= ^fifo_data ^ 1'(PARITY_ODD);
          tx    <= 1'b0;
          state <= START;
        end
        START: if (bit_end) begin
          tx      <= shift[0];
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (bit_end) begin
          shift <= shift_nxt;
          if (bit_idx == BW'(DATA_WIDTH - 1)) begin
            bit_idx <= '0;
            tx      <= (PARITY_EN != 0) ? par : 1'b1;
            state   <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx <= bit_idx + BW'(1);
            tx      <= shift_nxt[0];
          end
        end
        PARITY: if (bit_end) begin
          tx    <= 1'b1;
          state <= STOP;
        end
        STOP: if (bit_end) begin
          if (bit_idx == BW'(STOP_BITS - 1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b1;
            frames_sent <= frames_sent + 16'd1;
          end else begin
            bit_idx <= bit_idx + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the team's 8-bit synchronous FIFO.
- Pops one word at a time from the FIFO read port and serialises it as an asynchronous UART frame: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
- Paced by an internal baud divider.
- Reports frame completion and keeps a running count of frames sent.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and number of data bits per frame.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 allows new frames to start; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after a rd_en pulse.
- fifo_rd_en  output  1  registered one-cycle pop request to the FIFO.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-cycle pulse after last stop bit.
- frames_sent  output  16  count of completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, frames_sent=0.
  - Shift register, bit counter and baud counter all cleared.
  - A frame in flight is abandoned; its popped word is discarded.
- All outputs are registered. No combinational path from inputs to outputs.

State machine (IDLE, POP, WAIT, START, DATA, PARITY, STOP):
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0 at the edge, go to POP.
  - Otherwise stay in IDLE.
  - fifo_empty is sampled only here, so fifo_rd_en is never raised toward an empty FIFO.
- POP:
  - fifo_rd_en=1 for exactly this one cycle; tx=1.
  - Next state WAIT.
- WAIT:
  - fifo_rd_en=0; tx=1.
  - At the end of this cycle, capture fifo_data into the shift register and compute the parity bit: XOR of data, inverted if PARITY_ODD=1.
  - Next state START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Next state DATA.
- DATA:
  - tx=shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY:
  - tx=parity bit for CLKS_PER_BIT cycles.
  - Next state STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Then return to IDLE, with frame_done=1 and frames_sent+1 in that first IDLE cycle.

Timing:
- If fifo_rd_en is high in cycle T, tx falls at cycle T+2.
- Each bit is held exactly CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
- Back-to-back frames: minimum inter-frame idle is 3 cycles of tx=1 beyond the stop bits (IDLE, POP, WAIT).
- Frame length in clk cycles: CLKS_PER_BIT*(1+DATA_WIDTH+PARITY_EN+STOP_BITS).

Boundary conditions:
- enable dropped mid-frame: the current frame completes normally; no further pop until enable=1 in IDLE.
- fifo_empty toggling while not in IDLE: ignored.
- frame_done and a new pop decision coincide in the same IDLE cycle. Both are legal: frame_done pulses while the next POP is being decided.
- frames_sent is a 16-bit unsigned count and wraps without a flag.

Test Plan:
- CLKS_PER_BIT=4, no parity, 1 stop; push 0xA5, enable=1:
  - exactly one fifo_rd_en pulse;
  - tx from T+2 = 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles);
  - frame_done one pulse; frames_sent=1.
- Push 0x11, 0x22, 0x33 back-to-back:
  - three rd_en pulses;
  - decoded bytes 0x11, 0x22, 0x33 in order;
  - tx high exactly 4+3 cycles between start bits' preceding stop/idle;
  - frames_sent=3.
- FIFO empty, enable=1 for 200 cycles -> fifo_rd_en never asserted, tx=1, busy=0.
- PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2; send 0x03 -> parity bit 1, followed by 8 cycles of tx=1. Repeat with PARITY_ODD=0 -> parity bit 0.
- Assert reset during the 3rd data bit:
  - same-cycle tx=1, busy=0, fifo_rd_en=0, frames_sent=0;
  - after release with FIFO non-empty, the next word is sent cleanly.
- Drop enable during the start bit with 2 words queued -> the first frame completes, frame_done pulses, no second rd_en until enable returns.
